// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing generator.
// A clock divider produces a one-clk pix_en pulse every CLK_DIV clocks; on
// that pulse the column/line counters advance and the sync/bright decode is
// registered from the next counter values, so decode and counters always agree.
// Optional feature macro: VGA_FRAME_TICK_EN adds a frame_tick output that
// pulses at the start of vertical blanking.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_HI  = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_VIS_LO  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_HI  = 10'(V_SYNC + V_BP + V_ACTIVE);

    logic [DW-1:0] div_q, div_d;
    logic          pix_en_q, pix_en_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          bright_q, bright_d;
    logic          adv;

    // Next-state: divider, pixel advance, and decode from the next counters.
    always_comb begin
        adv      = (div_q == DIV_LAST);
        div_d    = adv ? '0 : div_q + 1'b1;
        pix_en_d = adv;
        h_d      = h_q;
        v_d      = v_q;
        if (adv) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        hsync_d  = !(h_d < H_SYNC_W);
        vsync_d  = !(v_d < V_SYNC_W);
        bright_d = (h_d >= H_VIS_LO) && (h_d < H_VIS_HI) &&
                   (v_d >= V_VIS_LO) && (v_d < V_VIS_HI);
    end

    // State registers; reset wins over a coincident advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
        end
    end

    assign pix_en = pix_en_q;
    assign hCount = h_q;
    assign vCount = v_q;
    assign hSync  = hsync_q;
    assign vSync  = vsync_q;
    assign bright = bright_q;

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_q, frame_tick_d;

    // Start of vertical blanking: the advance that lands on (0, first blank line).
    always_comb begin
        frame_tick_d = adv && (h_d == '0) && (v_d == V_VIS_HI);
    end

    // Frame tick register.
    always_ff @(posedge clk) begin
        if (reset) frame_tick_q <= 1'b0;
        else       frame_tick_q <= frame_tick_d;
    end

    assign frame_tick = frame_tick_q;
`endif

endmodule
